// File: rtl/mt_reg_file.sv
// Multithreaded MIPS register file: per-thread banks, two combinational read ports,
// one write port with bypass, a per-thread clear engine and a post-reset zeroing sweep.
module mt_reg_file #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int NUM_THREADS = 2,
    localparam int ADDR_W     = $clog2(NUM_REGS),
    localparam int TID_W      = $clog2(NUM_THREADS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TID_W-1:0]      rd_tid,
    input  logic                  rs_en,
    input  logic [ADDR_W-1:0]     rs_addr,
    input  logic                  rt_en,
    input  logic [ADDR_W-1:0]     rt_addr,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  wr_en,
    input  logic [TID_W-1:0]      wr_tid,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr_valid,
    input  logic [TID_W-1:0]      clr_tid,
    output logic                  clr_ready,
    output logic                  clr_done
);

    localparam int FLAT_W = TID_W + ADDR_W;
    localparam int TOTAL  = NUM_THREADS * NUM_REGS;
    localparam logic [FLAT_W-1:0] LAST_FLAT = FLAT_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [FLAT_W-1:0]     ctr_q, ctr_d;
    logic [TID_W-1:0]      cur_tid_q, cur_tid_d;
    logic                  clr_ready_q, clr_ready_d;
    logic                  clr_done_q, clr_done_d;
    logic [DATA_WIDTH-1:0] mem_q [TOTAL];

    logic                  in_init_s;
    logic                  in_clear_s;
    logic                  wr_ok_s;
    logic                  stall_s;
    logic                  mem_we_s;
    logic [FLAT_W-1:0]     mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;

    // Write acceptance: INIT ignores writes, CLEAR drops writes to the thread being cleared.
    always_comb begin
        in_init_s  = (state_q == ST_INIT);
        in_clear_s = (state_q == ST_CLEAR);
        stall_s    = in_clear_s && wr_en && (wr_tid != cur_tid_q);
        wr_ok_s    = wr_en && !in_init_s && !(in_clear_s && (wr_tid == cur_tid_q));
    end

    // Single storage write port arbitration between sweep, write-back and clear.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        if (in_init_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = ctr_q;
        end else if (wr_ok_s) begin
            // A write-back to another thread owns the port even while clearing.
            mem_we_s    = (wr_addr != '0);
            mem_waddr_s = {wr_tid, wr_addr};
            mem_wdata_s = wr_data;
        end else if (in_clear_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = {cur_tid_q, ctr_q[ADDR_W-1:0]};
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array; intentionally not reset, the INIT sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Next-state logic for the INIT / IDLE / CLEAR sequencer.
    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        cur_tid_d   = cur_tid_q;
        clr_ready_d = clr_ready_q;
        clr_done_d  = 1'b0;
        case (state_q)
            ST_INIT: begin
                clr_ready_d = 1'b0;
                if (ctr_q == LAST_FLAT) begin
                    state_d     = ST_IDLE;
                    ctr_d       = '0;
                    clr_ready_d = 1'b1;
                end else begin
                    ctr_d = ctr_q + FLAT_W'(1);
                end
            end
            ST_IDLE: begin
                clr_ready_d = 1'b1;
                if (clr_valid) begin
                    state_d     = ST_CLEAR;
                    cur_tid_d   = clr_tid;
                    ctr_d       = FLAT_W'(1);
                    clr_ready_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_ready_d = 1'b0;
                if (stall_s) begin
                    ctr_d = ctr_q;
                end else if (ctr_q[ADDR_W-1:0] == LAST_REG) begin
                    state_d     = ST_IDLE;
                    ctr_d       = '0;
                    clr_ready_d = 1'b1;
                    clr_done_d  = 1'b1;
                end else begin
                    ctr_d = ctr_q + FLAT_W'(1);
                end
            end
            default: begin
                state_d     = ST_INIT;
                ctr_d       = '0;
                clr_ready_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            ctr_q       <= '0;
            cur_tid_q   <= '0;
            clr_ready_q <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            cur_tid_q   <= cur_tid_d;
            clr_ready_q <= clr_ready_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign clr_ready = clr_ready_q;
    assign clr_done  = clr_done_q;

    // rs read port: forced zero, then same-cycle bypass, then storage.
    always_comb begin
        if (!rs_en || (rs_addr == '0) || in_init_s || (in_clear_s && (rd_tid == cur_tid_q))) begin
            rs_data = '0;
        end else if (wr_ok_s && (wr_tid == rd_tid) && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end else begin
            rs_data = mem_q[{rd_tid, rs_addr}];
        end
    end

    // rt read port: same priority as rs.
    always_comb begin
        if (!rt_en || (rt_addr == '0) || in_init_s || (in_clear_s && (rd_tid == cur_tid_q))) begin
            rt_data = '0;
        end else if (wr_ok_s && (wr_tid == rd_tid) && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end else begin
            rt_data = mem_q[{rd_tid, rt_addr}];
        end
    end

endmodule

// File: tb/tb_mt_reg_file.sv
// Self-checking bench for mt_reg_file: directed scenarios plus random traffic
// against a thread-bank reference model.
module tb_mt_reg_file;

    localparam int DW    = 32;
    localparam int NR    = 32;
    localparam int NT    = 2;
    localparam int AW    = $clog2(NR);
    localparam int TW    = $clog2(NT);
    localparam int TOTAL = NR * NT;

    logic          clk;
    logic          rst_n;
    logic [TW-1:0] rd_tid;
    logic          rs_en;
    logic [AW-1:0] rs_addr;
    logic          rt_en;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          wr_en;
    logic [TW-1:0] wr_tid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr_valid;
    logic [TW-1:0] clr_tid;
    logic          clr_ready;
    logic          clr_done;

    mt_reg_file #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_THREADS(NT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_tid(rd_tid), .rs_en(rs_en), .rs_addr(rs_addr),
        .rt_en(rt_en), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .wr_en(wr_en), .wr_tid(wr_tid), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_valid(clr_valid), .clr_tid(clr_tid),
        .clr_ready(clr_ready), .clr_done(clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural contents per {tid, addr} plus busy counters.
    logic [DW-1:0] ref_mem [TOTAL];
    bit m_init;
    int m_init_left;
    bit m_clr;
    int m_clr_tid;
    int m_clr_left;
    bit m_done;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_init      = 1'b1;
        m_init_left = TOTAL;
        m_clr       = 1'b0;
        m_done      = 1'b0;
        for (int i = 0; i < TOTAL; i++) ref_mem[i] = '0;
    endtask

    function automatic logic [DW-1:0] exp_read(input logic en, input logic [AW-1:0] a);
        if (!en || a == 0 || m_init || (m_clr && int'(rd_tid) == m_clr_tid)) return '0;
        if (wr_en && !(m_clr && int'(wr_tid) == m_clr_tid) && wr_tid == rd_tid && wr_addr == a)
            return wr_data;
        return ref_mem[{rd_tid, a}];
    endfunction

    task automatic model_tick();
        m_done = 1'b0;
        if (m_init) begin
            m_init_left--;
            if (m_init_left == 0) m_init = 1'b0;
        end else if (m_clr) begin
            if (wr_en && int'(wr_tid) != m_clr_tid) begin
                if (wr_addr != 0) ref_mem[{wr_tid, wr_addr}] = wr_data;
            end else begin
                m_clr_left--;
                if (m_clr_left == 0) begin
                    m_clr  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else begin
            if (wr_en && wr_addr != 0) ref_mem[{wr_tid, wr_addr}] = wr_data;
            if (clr_valid) begin
                m_clr      = 1'b1;
                m_clr_tid  = int'(clr_tid);
                m_clr_left = NR - 1;
                for (int a = 0; a < NR; a++) ref_mem[m_clr_tid * NR + a] = '0;
            end
        end
    endtask

    // Called at posedge+1: wait to mid-cycle and compare every output with the model.
    task automatic sample();
        if (!rst_n) model_reset();
        #4;
        check_eq("rs_data", rs_data, exp_read(rs_en, rs_addr));
        check_eq("rt_data", rt_data, exp_read(rt_en, rt_addr));
        check_eq("clr_ready", clr_ready, !m_init && !m_clr);
        check_eq("clr_done", clr_done, m_done);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_tick();
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic rand_rd();
        rd_tid  = TW'($urandom);
        rs_en   = ($urandom_range(0, 3) != 0);
        rs_addr = AW'($urandom);
        rt_en   = ($urandom_range(0, 3) != 0);
        rt_addr = AW'($urandom);
    endtask

    task automatic read_all(input int t, input bit expect_zero);
        wr_en = 1'b0;
        for (int a = 0; a < NR; a++) begin
            rd_tid  = TW'(t);
            rs_en   = 1'b1;
            rs_addr = AW'(a);
            rt_en   = 1'b1;
            rt_addr = AW'(NR - 1 - a);
            sample();
            if (expect_zero) check_eq("bank_zero", rs_data, 0);
            advance();
        end
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int n = 0;
        while (!clr_ready && n < 400) begin
            rand_rd();
            step();
            n++;
        end
        if (exp_cycles >= 0) check_eq(tag, n, exp_cycles);
        else check_eq(tag, clr_ready, 1'b1);
    endtask

    logic [DW-1:0] saved [4];

    initial begin
        int n;
        rst_n = 1'b1; rd_tid = '0; rs_en = 1'b0; rs_addr = '0; rt_en = 1'b0; rt_addr = '0;
        wr_en = 1'b0; wr_tid = '0; wr_addr = '0; wr_data = '0; clr_valid = 1'b0; clr_tid = '0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rs_en = 1'b1; rs_addr = AW'(3); rt_en = 1'b1; rt_addr = AW'(7);
        step();
        step();

        // Reset release: INIT sweep, writes must be ignored meanwhile.
        rst_n = 1'b1;
        n = 0;
        while (!clr_ready && n < 400) begin
            rand_rd();
            wr_en = $urandom_range(0, 1) == 1; wr_tid = TW'($urandom);
            wr_addr = AW'($urandom); wr_data = $urandom;
            step();
            n++;
        end
        check_eq("init_len", n, TOTAL);
        read_all(0, 1'b1);
        read_all(1, 1'b1);

        // Write then read with bypass.
        wr_en = 1'b1; wr_tid = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEADBEEF;
        rd_tid = 1'b1; rs_en = 1'b1; rs_addr = AW'(5); rt_en = 1'b1; rt_addr = AW'(5);
        sample();
        check_eq("bypass_rs", rs_data, 32'hDEADBEEF);
        advance();
        wr_en = 1'b0;
        sample();
        check_eq("stored_rs", rs_data, 32'hDEADBEEF);
        advance();
        rd_tid = 1'b0;
        sample();
        check_eq("t0_r5", rt_data, 0);
        advance();

        // r0 is hard-wired; disabled port returns zero.
        wr_en = 1'b1; wr_tid = 1'b0; wr_addr = AW'(0); wr_data = 32'h1234;
        rd_tid = 1'b0; rs_en = 1'b1; rs_addr = AW'(0);
        step();
        wr_en = 1'b0;
        step();
        rd_tid = 1'b1; rs_en = 1'b0; rs_addr = AW'(5);
        sample();
        check_eq("rs_en_off", rs_data, 0);
        advance();

        // Fill both banks with nonzero data.
        for (int t = 0; t < NT; t++) begin
            for (int a = 1; a < NR; a++) begin
                rand_rd();
                wr_en = 1'b1; wr_tid = TW'(t); wr_addr = AW'(a); wr_data = $urandom | 32'h1;
                step();
            end
        end
        wr_en = 1'b0;

        // Clear thread 1; a write to it mid-clear is dropped.
        clr_valid = 1'b1; clr_tid = 1'b1;
        step();
        clr_valid = 1'b0;
        n = 0;
        while (!clr_done && n < 200) begin
            rand_rd();
            if (n == 5) begin
                wr_en = 1'b1; wr_tid = 1'b1; wr_addr = AW'(3); wr_data = 32'hABCD;
                rd_tid = 1'b1; rs_en = 1'b1; rs_addr = AW'(3);
            end else begin
                wr_en = 1'b0;
            end
            step();
            n++;
        end
        wr_en = 1'b0;
        check_eq("clr_len", n, NR - 1);
        read_all(1, 1'b1);
        read_all(0, 1'b0);

        // Clear with four write-back stalls to thread 0.
        clr_valid = 1'b1; clr_tid = 1'b1;
        step();
        clr_valid = 1'b0;
        n = 0;
        while (!clr_done && n < 200) begin
            rand_rd();
            if (n >= 3 && n < 7) begin
                wr_en = 1'b1; wr_tid = 1'b0; wr_addr = AW'(n + 10);
                wr_data = $urandom | 32'h100; saved[n - 3] = wr_data;
            end else begin
                wr_en = 1'b0;
            end
            step();
            n++;
        end
        wr_en = 1'b0;
        check_eq("stall_len", n, NR - 1 + 4);
        for (int i = 0; i < 4; i++) begin
            rd_tid = 1'b0; rs_en = 1'b1; rs_addr = AW'(13 + i);
            sample();
            check_eq("stall_wr", rs_data, saved[i]);
            advance();
        end

        // Random traffic including clears.
        for (int c = 0; c < 1500; c++) begin
            rand_rd();
            wr_en = $urandom_range(0, 1) == 1; wr_tid = TW'($urandom);
            wr_addr = AW'($urandom); wr_data = $urandom;
            clr_valid = $urandom_range(0, 15) == 0; clr_tid = TW'($urandom);
            step();
        end
        wr_en = 1'b0; clr_valid = 1'b0;
        wait_ready("idle_after_rand", -1);

        // Reset in the middle of a clear.
        clr_valid = 1'b1; clr_tid = 1'b1;
        step();
        clr_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            rand_rd();
            step();
        end
        rst_n = 1'b0;
        rand_rd();
        step();
        rand_rd();
        step();
        rst_n = 1'b1;
        wait_ready("reinit_len", TOTAL);
        read_all(0, 1'b1);
        read_all(1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
